// File: rtl/activation_pkg.sv
// activation_pkg: shared types and helpers for the activation pipeline.
// Holds the activation mode encoding and the output clamp bound helpers.
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_RELU  = 2'd0,
        ACT_LEAKY = 2'd1,
        ACT_IDENT = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_t;

    // Largest value representable in a signed dw-bit word.
    function automatic int clamp_hi(int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Smallest value representable in a signed dw-bit word.
    function automatic int clamp_lo(int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/activation_lane.sv
// activation_lane: one channel of the activation datapath.
// Ports: clk/reset; ld1/ld2 stage loads; mode (stage-1 beat mode);
// sum in; data/sat registered clamped activation and saturation flag.
module activation_lane
    import activation_pkg::*;
#(
    parameter int sumWidth  = 16,
    parameter int dataWidth = 8,
    parameter int fracShift = 0,
    parameter int leakShift = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld1,
    input  logic                 ld2,
    input  act_mode_t            mode,
    input  logic [sumWidth-1:0]  sum,
    output logic [dataWidth-1:0] data,
    output logic                 sat
);

    localparam logic signed [sumWidth-1:0] hi =
        sumWidth'(clamp_hi(dataWidth));
    localparam logic signed [sumWidth-1:0] lo =
        sumWidth'(clamp_lo(dataWidth));

    logic signed [sumWidth-1:0] s1;
    logic signed [sumWidth-1:0] a;
    logic [dataWidth-1:0]       d2;
    logic                       s2;

    always_comb begin
        a = s1;
        case (mode)
            ACT_LEAKY: a = s1[sumWidth-1] ? (s1 >>> leakShift) : s1;
            ACT_IDENT: a = s1;
            default:   a = s1[sumWidth-1] ? '0 : s1;
        endcase
    end

    // Full-width signed compare, so large sums never wrap into range.
    always_comb begin
        d2 = a[dataWidth-1:0];
        s2 = 1'b0;
        if (a > hi) begin
            d2 = hi[dataWidth-1:0];
            s2 = 1'b1;
        end else if (a < lo) begin
            d2 = lo[dataWidth-1:0];
            s2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            data <= '0;
            sat  <= 1'b0;
        end else begin
            if (ld1) s1 <= $signed(sum) >>> fracShift;
            if (ld2) begin
                data <= d2;
                sat  <= s2;
            end
        end
    end

endmodule

// File: rtl/activation_pipe.sv
// activation_pipe: two-stage rescale/activate/clamp pipe with backpressure.
// Ports: clk, reset; inValid/inReady/mode/sumIn input beat;
// outValid/outReady/dataOut/satOut output beat; satClear/satCount counter.
module activation_pipe
    import activation_pkg::*;
#(
    parameter int sumWidth  = 16,
    parameter int dataWidth = 8,
    parameter int numLanes  = 4,
    parameter int fracShift = 0,
    parameter int leakShift = 3,
    parameter int cntWidth  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inValid,
    output logic                          inReady,
    input  logic [1:0]                    mode,
    input  logic [numLanes*sumWidth-1:0]  sumIn,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [numLanes*dataWidth-1:0] dataOut,
    output logic [numLanes-1:0]           satOut,
    input  logic                          satClear,
    output logic [cntWidth-1:0]           satCount
);

    logic      v1, v2;
    logic      en1, en2;
    logic      ld1, ld2;
    logic      inc;
    act_mode_t m1;

    // A stage advances when it is empty or its successor advances.
    assign en2      = !v2 || outReady;
    assign en1      = !v1 || en2;
    assign inReady  = en1;
    assign ld1      = en1 && inValid;
    assign ld2      = en2 && v1;
    assign outValid = v2;
    assign inc      = v2 && outReady && (|satOut);

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            m1 <= ACT_RELU;
        end else begin
            if (en1) v1 <= inValid;
            if (ld1) m1 <= act_mode_t'(mode);
            if (en2) v2 <= v1;
        end
    end

    // Clear has priority; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || satClear) begin
            satCount <= '0;
        end else if (inc && !(&satCount)) begin
            satCount <= satCount + cntWidth'(1);
        end
    end

    for (genvar i = 0; i < numLanes; i++) begin : g_lane
        activation_lane #(
            .sumWidth (sumWidth),
            .dataWidth(dataWidth),
            .fracShift(fracShift),
            .leakShift(leakShift)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .ld1  (ld1),
            .ld2  (ld2),
            .mode (m1),
            .sum  (sumIn[i*sumWidth +: sumWidth]),
            .data (dataOut[i*dataWidth +: dataWidth]),
            .sat  (satOut[i])
        );
    end

endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: scoreboard bench for activation_pipe.
// Driver pushes expected beats on accept; a monitor pops on output.
module tb_activation_pipe;
    import activation_pkg::*;

    localparam int SW = 16;
    localparam int DW = 8;
    localparam int NL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, inValid, inReady, outValid, outReady, satClear;
    logic [1:0]     mode;
    logic [NL*SW-1:0] sumIn;
    logic [NL*DW-1:0] dataOut;
    logic [NL-1:0]  satOut;
    logic [15:0]    satCount;

    logic           reset2, inValid2, inReady2, outValid2, outReady2;
    logic           satClear2;
    logic [1:0]     mode2;
    logic [NL*SW-1:0] sumIn2;
    logic [NL*DW-1:0] dataOut2;
    logic [NL-1:0]  satOut2;
    logic [2:0]     satCount2;

    activation_pipe dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .mode(mode), .sumIn(sumIn), .outValid(outValid),
        .outReady(outReady), .dataOut(dataOut), .satOut(satOut),
        .satClear(satClear), .satCount(satCount)
    );

    activation_pipe #(.fracShift(4), .cntWidth(3)) dut2 (
        .clk(clk), .reset(reset2), .inValid(inValid2),
        .inReady(inReady2), .mode(mode2), .sumIn(sumIn2),
        .outValid(outValid2), .outReady(outReady2),
        .dataOut(dataOut2), .satOut(satOut2),
        .satClear(satClear2), .satCount(satCount2)
    );

    typedef struct {
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    sat;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic on the activation rules.
    function automatic logic [8:0] ref_lane(input logic [15:0] sum,
                                            input logic [1:0] m,
                                            input int frac);
        int s, a;
        s = int'($signed(sum)) >>> frac;
        a = s;
        if (s < 0) begin
            if (m == 2'd1) a = s >>> 3;
            else if (m != 2'd2) a = 0;
        end
        if (a > 127) return {1'b1, 8'h7f};
        if (a < -128) return {1'b1, 8'h80};
        return {1'b0, a[7:0]};
    endfunction

    function automatic beat_t ref_beat(input logic [NL*SW-1:0] s,
                                       input logic [1:0] m, input int frac);
        beat_t b;
        logic [8:0] r;
        for (int i = 0; i < NL; i++) begin
            r = ref_lane(s[i*SW +: SW], m, frac);
            b.data[i*DW +: DW] = r[7:0];
            b.sat[i] = r[8];
        end
        return b;
    endfunction

    function automatic logic [15:0] small_sum();
        int v;
        v = int'($urandom_range(0, 200)) - 100;
        return v[15:0];
    endfunction

    // Monitor: counter model, stall stability, scoreboard pop.
    logic [15:0]      exp_cnt = '0;
    logic             stall_p = 1'b0;
    logic [NL*DW-1:0] pd;
    logic [NL-1:0]    ps;
    beat_t            me;
    logic             satq;

    always @(negedge clk) begin
        check("satCount", satCount, exp_cnt);
        if (stall_p) begin
            check("hold valid", outValid, 1);
            check("hold data", dataOut, pd);
            check("hold sat", satOut, ps);
        end
        satq = 1'b0;
        if (reset) begin
            exp_cnt = '0;
            stall_p = 1'b0;
        end else begin
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    check("spurious out", outValid, 0);
                end else begin
                    me = sb.pop_front();
                    check("dataOut", dataOut, me.data);
                    check("satOut", satOut, me.sat);
                    satq = |me.sat;
                end
            end
            if (satClear) exp_cnt = '0;
            else if (satq && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 1;
            stall_p = outValid && !outReady;
            pd = dataOut;
            ps = satOut;
        end
    end

    task automatic offer(input logic [NL*SW-1:0] s, input logic [1:0] m,
                         input beat_t e);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        inValid = 1'b1;
        sumIn = s;
        mode = m;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = inReady;
            if (acc) sb.push_back(e);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept timeout", acc, 1);
        inValid = 1'b0;
    endtask

    task automatic send(input logic [15:0] l0, input logic [1:0] m,
                        input logic [7:0] e0, input logic es0);
        beat_t e;
        logic [NL*SW-1:0] s;
        s = '0;
        for (int i = 1; i < NL; i++) s[i*SW +: SW] = small_sum();
        s[SW-1:0] = l0;
        e = ref_beat(s, m, 0);
        e.data[DW-1:0] = e0;
        e.sat[0] = es0;
        offer(s, m, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        outReady = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, sent, n;
        reset = 1'b1; inValid = 1'b0; outReady = 1'b0; satClear = 1'b0;
        mode = 2'd0; sumIn = '0;
        reset2 = 1'b1; inValid2 = 1'b0; outReady2 = 1'b0;
        satClear2 = 1'b0; mode2 = 2'd0; sumIn2 = '0;

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst outValid", outValid, 0);
        check("rst inReady", inReady, 1);
        check("rst dataOut", dataOut, 0);
        check("rst satOut", satOut, 0);
        check("rst satCount", satCount, 0);
        reset = 1'b0;

        // Latency of an unstalled beat.
        outReady = 1'b1;
        send(16'h0050, 2'd0, 8'h50, 1'b0);
        lat = 1;
        while (!outValid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 2);
        drain();

        // RELU, LEAKY, IDENT directed values.
        send(16'h0050, 2'd0, 8'h50, 1'b0);
        send(16'h0200, 2'd0, 8'h7f, 1'b1);
        send(16'hfff0, 2'd0, 8'h00, 1'b0);
        send(16'h0180, 2'd0, 8'h7f, 1'b1);
        send(16'hfff0, 2'd1, 8'hfe, 1'b0);
        send(16'h8000, 2'd1, 8'h80, 1'b1);
        send(16'h0030, 2'd1, 8'h30, 1'b0);
        send(16'hfff0, 2'd2, 8'hf0, 1'b0);
        send(16'hff00, 2'd2, 8'h80, 1'b1);
        send(16'h0200, 2'd3, 8'h7f, 1'b1);
        drain();

        // Per-beat mode switching on identical input.
        send(16'hfff0, 2'd0, 8'h00, 1'b0);
        send(16'hfff0, 2'd1, 8'hfe, 1'b0);
        send(16'hfff0, 2'd2, 8'hf0, 1'b0);
        drain();

        // Full pipe under stall, then one ready pulse.
        outReady = 1'b0;
        send(16'h0011, 2'd2, 8'h11, 1'b0);
        send(16'h0022, 2'd2, 8'h22, 1'b0);
        check("full inReady", inReady, 0);
        outReady = 1'b1;
        #1;
        check("pulse inReady", inReady, 1);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check("freed inReady", inReady, 1);
        drain();

        // Random backpressure stream.
        sent = 0;
        n = 0;
        while (sent < 10 && n < 300) begin
            outReady = 1'($urandom_range(0, 1));
            inValid = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
            sumIn = {$urandom, $urandom};
            @(negedge clk);
            if (inValid && inReady) begin
                sb.push_back(ref_beat(sumIn, mode, 0));
                sent++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        inValid = 1'b0;
        check("bp sent", sent, 10);
        drain();

        // Counter: three hits, then clear racing a fourth.
        do_reset();
        outReady = 1'b1;
        repeat (3) send(16'h0200, 2'd0, 8'h7f, 1'b1);
        drain();
        check("cnt three", satCount, 3);
        outReady = 1'b0;
        send(16'h0200, 2'd0, 8'h7f, 1'b1);
        n = 0;
        while (!outValid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cnt4 valid", outValid, 1);
        outReady = 1'b1;
        satClear = 1'b1;
        @(posedge clk);
        #1;
        satClear = 1'b0;
        check("cnt clear", satCount, 0);
        drain();

        // Reset with two beats in flight.
        send(16'h0200, 2'd0, 8'h7f, 1'b1);
        drain();
        check("cnt pre-rst", satCount, 1);
        outReady = 1'b0;
        send(16'h0200, 2'd0, 8'h7f, 1'b1);
        send(16'h0033, 2'd0, 8'h33, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check("mid-rst valid", outValid, 0);
        check("mid-rst cnt", satCount, 0);
        check("mid-rst ready", inReady, 1);
        reset = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post-rst valid", outValid, 0);

        // fracShift=4, 3-bit counter instance.
        reset2 = 1'b0;
        outReady2 = 1'b1;
        inValid2 = 1'b1;
        sumIn2 = '0;
        sumIn2[SW-1:0] = 16'h07f0;
        @(posedge clk);
        #1;
        inValid2 = 1'b0;
        @(posedge clk);
        #1;
        check("f4 valid", outValid2, 1);
        check("f4 data", dataOut2[DW-1:0], 8'h7f);
        check("f4 sat", satOut2[0], 0);
        sumIn2[SW-1:0] = 16'h7ff0;
        inValid2 = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        inValid2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("f4 sat data", dataOut2[DW-1:0], 8'h7f);
        check("f4 sat flag", satOut2[0], 1);
        check("cnt hold max", satCount2, 3'h7);

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/activation_pipe.md
# activation_pipe

Parametrised, pipelined activation stage that sits between each neuron layer's accumulator outputs and the next layer's inputs. Takes `numLanes` signed `sumWidth` accumulator sums per beat, rescales them, applies a run-time-selected activation (saturating ReLU, leaky ReLU, or identity), and clamps the result to signed `dataWidth`. It moves data with a valid/ready handshake and full backpressure, and keeps a saturation event counter for quantisation debugging.

## Interface
- `sumWidth`, 16, width of each signed accumulator sum
- `dataWidth`, 8, width of each signed output activation
- `numLanes`, 4, number of parallel channels per beat
- `fracShift`, 0, arithmetic right shift applied to each sum before activation (fixed-point rescale)
- `leakShift`, 3, arithmetic right shift giving the leaky-ReLU negative slope (2^-leakShift)
- `cntWidth`, 16, width of the saturation counter
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `inValid`  in  1  input beat valid
- `inReady`  out  1  block can accept an input beat
- `mode`  in  2  activation mode, sampled with each accepted beat
- `sumIn`  in  numLanes*sumWidth  packed signed sums; lane i at [i*sumWidth +: sumWidth]
- `outValid`  out  1  output beat valid
- `outReady`  in  1  downstream accepts output beat
- `dataOut`  out  numLanes*dataWidth  packed signed activations; lane i at [i*dataWidth +: dataWidth]
- `satOut`  out  numLanes  per-lane saturation flag, aligned with `dataOut`
- `satClear`  in  1  clears the saturation counter
- `satCount`  out  cntWidth  number of output beats with at least one saturated lane

## Operation
- Modes: 0 RELU, 1 LEAKY, 2 IDENT, 3 reserved (behaves as RELU). The mode travels with its beat, so mid-stream mode changes affect only newly accepted beats.
- Per lane, stage 1 (registered): s = sumIn_lane >>> fracShift (arithmetic, sign-preserving, full sumWidth).
- Stage 1 activation:
  - RELU: a = (s < 0) ? 0 : s
  - LEAKY: a = (s < 0) ? (s >>> leakShift) : s
  - IDENT: a = s
- Stage 2 (registered): clamp a to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
  - The sign bit must be used. A positive sum whose low bits look small, e.g. 0x0180, must clamp to 0x7F and must not be truncated.
  - satOut lane = 1 when clamping changed the value. RELU zeroing of a negative sum is not saturation.
- Counter: increments by 1 on each output handshake (outValid && outReady) where |satOut != 0. It holds at all-ones and never wraps.
  - satClear zeroes the counter. If satClear coincides with an increment, clear wins and the result is 0.
- Reset: outValid=0, inReady=1 (the pipe is empty), dataOut=0, satOut=0, satCount=0, internal valids and data 0.
  - Reset mid-stream drops all in-flight beats with no output produced.

## Timing
- Two register stages. Latency is exactly 2 cycles from input handshake to outValid when unstalled. Throughput is 1 beat/cycle.
- Stage enables:
  - en2 = !v2 || outReady
  - en1 = !v1 || en2
  - inReady = en1
- The combinational path from outReady to inReady is allowed. No other combinational input-to-output paths exist.
- While outValid=1 and outReady=0, dataOut, satOut and outValid hold stable. No beat is lost or duplicated.
- Empty pipe: inReady=1 regardless of outReady.
- Full pipe with stall: inReady=0. A single outReady pulse frees one slot, and inReady rises in the same cycle.
- satCount updates the cycle after the qualifying handshake.

## Structure
- Package `activation_pkg` holds:
  - typedef enum logic [1:0] `act_mode_t` {ACT_RELU, ACT_LEAKY, ACT_IDENT, ACT_RSVD}
  - a function computing the clamp bounds from dataWidth
- Sub-module `activation_lane` contains the per-lane shift, mode and clamp datapath with its two data registers. It is generated numLanes times.
- The top level owns the valid/ready control, the mode pipeline register, and the saturation counter.

## Test plan
All scenarios use defaults. Lane 0 is shown; the other lanes are randomised with the same checks.
- RELU, sumIn 0x0050 → 0x50, sat 0. Sum 0x0200 → 0x7F, sat 1, satCount 1. Sum 0xFFF0 → 0x00, sat 0. Sum 0x0180 → 0x7F.
- LEAKY, sumIn 0xFFF0 (−16) → 0xFE (−2). Sum 0x8000 → 0x80, sat 1. Sum 0x0030 → 0x30.
- IDENT, sumIn 0xFFF0 → 0xF0. Sum 0xFF00 → 0x80 with sat 1. With fracShift=4, sum 0x07F0 → 0x7F, sat 0.
- Backpressure: stream 10 beats with outReady toggling pseudo-randomly. Outputs must match the inputs in order, with no drops or duplicates, and dataOut must be stable during stalls. The first output must appear 2 cycles after the first accept.
- Mode switching per beat (RELU, LEAKY, IDENT) on an identical input of 0xFFF0 → 0x00, 0xFE, 0xF0 in order.
- Counter: 3 saturating beats → 3. satClear on the same cycle as a 4th saturating handshake → 0. Forcing the counter to all-ones must hold there. Asserting reset with 2 beats in flight → outValid=0 next cycle and satCount=0.
